apb_timer_slave: RTL

- APB completer (slave) for one peripheral port (psel_sN / prdata_sN) of the AHB-to-APB bridge.
- Provides a 32-bit down-counting timer with prescaler, one-shot/periodic modes and a level interrupt.
- Uses zero-wait-state APB2 timing: no pready, no pslverr.
- Runs on the bridge clock and reset; APB accesses are qualified by pclk_en.

---
 rtl/apb_timer_slave_if.sv | 19 +
 rtl/apb_timer_slave.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/apb_timer_slave_if.sv
// APB2 completer-side bus bundle for one bridge port of the timer slave.
interface apb_timer_slave_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata
  );
endinterface

// File: rtl/apb_timer_slave.sv
// Zero-wait-state APB2 timer peripheral: 32-bit down counter with prescaler,
// one-shot/periodic reload and a level interrupt (RIS & IE).
module apb_timer_slave #(
  parameter int unsigned PRESCALE_W = 8,
  parameter logic [31:0] LOAD_RESET = 32'h0000_FFFF
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  pclk_en,
  apb_timer_slave_if.slave      apb,
  output logic                  timer_irq
);

  typedef enum logic [2:0] {
    REG_LOAD   = 3'd0,
    REG_VALUE  = 3'd1,
    REG_CTRL   = 3'd2,
    REG_RIS    = 3'd3,
    REG_INTCLR = 3'd4,
    REG_MIS    = 3'd5,
    REG_RSVD6  = 3'd6,
    REG_RSVD7  = 3'd7
  } reg_e;

  logic [31:0]           load_q,     load_d;
  logic [31:0]           value_q,    value_d;
  logic                  en_q,       en_d;
  logic                  periodic_q, periodic_d;
  logic                  ie_q,       ie_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pcnt_q,     pcnt_d;
  logic                  ris_q,      ris_d;

  reg_e        sel;
  logic        wr_en;
  logic        wr_load;
  logic        wr_ctrl;
  logic        wr_intclr;
  logic        tick;
  logic        ris_set;
  logic [31:0] rd_data;
  logic        unused_addr;

  assign sel       = reg_e'(apb.paddr[4:2]);
  assign wr_en     = pclk_en & apb.psel & apb.penable & apb.pwrite;
  assign wr_load   = wr_en && (sel == REG_LOAD);
  assign wr_ctrl   = wr_en && (sel == REG_CTRL);
  assign wr_intclr = wr_en && (sel == REG_INTCLR);

  // A LOAD write suppresses the whole tick, so expiry (and its RIS set) is
  // only recognised when no LOAD write lands in the same cycle.
  assign tick      = en_q && (pcnt_q == prescale_q);
  assign ris_set   = tick && !wr_load && (value_q == '0);

  assign unused_addr = ^{apb.paddr[31:5], apb.paddr[1:0]};

  // Next-state: prescaler, counter and interrupt, then APB writes on top.
  always_comb begin
    load_d     = load_q;
    value_d    = value_q;
    en_d       = en_q;
    periodic_d = periodic_q;
    ie_d       = ie_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    ris_d      = ris_q;

    if (en_q) begin
      pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
    end

    if (tick && !wr_load) begin
      if (value_q != '0) begin
        value_d = value_q - 32'd1;
      end else begin
        ris_d = 1'b1;
        if (periodic_q) begin
          value_d = load_q;
        end else begin
          en_d = 1'b0;
        end
      end
    end

    if (wr_load) begin
      load_d  = apb.pwdata;
      value_d = apb.pwdata;
      pcnt_d  = '0;
    end

    if (wr_ctrl) begin
      en_d       = apb.pwdata[0];
      periodic_d = apb.pwdata[1];
      ie_d       = apb.pwdata[2];
      prescale_d = apb.pwdata[8 +: PRESCALE_W];
      if (!en_q && apb.pwdata[0]) begin
        pcnt_d = '0;
      end
    end

    if (wr_intclr && !ris_set) begin
      ris_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      load_q     <= LOAD_RESET;
      value_q    <= LOAD_RESET;
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      ie_q       <= 1'b0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      ris_q      <= 1'b0;
    end else begin
      load_q     <= load_d;
      value_q    <= value_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      ie_q       <= ie_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      ris_q      <= ris_d;
    end
  end

  // Read mux; output is forced to zero unless this port is selected for a read.
  always_comb begin
    rd_data = '0;
    case (sel)
      REG_LOAD:  rd_data = load_q;
      REG_VALUE: rd_data = value_q;
      REG_CTRL: begin
        rd_data[0]                = en_q;
        rd_data[1]                = periodic_q;
        rd_data[2]                = ie_q;
        rd_data[8 +: PRESCALE_W]  = prescale_q;
      end
      REG_RIS:   rd_data[0] = ris_q;
      REG_MIS:   rd_data[0] = ris_q & ie_q;
      default:   rd_data = '0;
    endcase
  end

  assign apb.prdata = (apb.psel && !apb.pwrite) ? rd_data : '0;
  assign timer_irq  = ris_q & ie_q;

endmodule
